// File: rtl/wash_controller.sv
// wash_controller
// ---------------
// Washing-machine sequencer that sits directly upstream of the stage timer.
// It walks the machine through door check, fill, heat, wash, rinse and spin.
// It publishes its state code to the timer and reacts to the timer's
// completion flags. It also drives the actuator enables and latches the door,
// runs a per-stage watchdog, and reports completion and faults.
//
// Ports
//   clock           system clock, everything on the rising edge
//   reset_n         synchronous active-low reset
//   start           user start request (level), honoured only in IDLE
//   door_closed     door switch, 1 = closed
//   cold_wash       1 = skip HEAT_WATER, looked at when FILL_WATER completes
//   clear           acknowledge: leaves DONE, clears a fault while in IDLE
//   sig_Full        fill complete (from timer)
//   sig_Temperature heat complete (from timer)
//   sig_Completed   wash / rinse / spin complete (from timer)
//   state           current state code (to timer)
//   water_valve, heater, motor_wash, motor_spin, drain_valve  actuator enables
//   door_lock       door latch, held in states 1..6
//   done            cycle finished, held in DONE
//   fault           00 none, 01 door opened, 10 stage timeout, 11 door never closed

module wash_controller #(
  parameter int STAGE_TIMEOUT = 16,
  parameter int TO_WIDTH      = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       door_closed,
  input  logic       cold_wash,
  input  logic       clear,
  input  logic       sig_Full,
  input  logic       sig_Temperature,
  input  logic       sig_Completed,
  output logic [2:0] state,
  output logic       water_valve,
  output logic       heater,
  output logic       motor_wash,
  output logic       motor_spin,
  output logic       drain_valve,
  output logic       door_lock,
  output logic       done,
  output logic [1:0] fault
);

  // The state codes are shared with the stage timer, so the values are fixed.
  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_DOOR_CHECK = 3'd1,
    S_FILL_WATER = 3'd2,
    S_HEAT_WATER = 3'd3,
    S_WASH       = 3'd4,
    S_RINSE      = 3'd5,
    S_SPIN       = 3'd6,
    S_DONE       = 3'd7
  } state_t;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_DOOR    = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;
  localparam logic [1:0] FAULT_NODOOR  = 2'b11;

  // The watchdog holds (cycles spent in the stage - 1). This value is the
  // last cycle a stage may occupy.
  localparam logic [TO_WIDTH-1:0] WD_LIMIT = TO_WIDTH'(STAGE_TIMEOUT - 1);

  state_t              cur_state;
  state_t              nxt_state;
  state_t              adv_state;
  logic [1:0]          nxt_fault;
  logic                stage_flag;
  logic                wd_hit;
  logic [TO_WIDTH-1:0] watchdog;
  logic [6:0]          nxt_outs;

  assign wd_hit = (watchdog == WD_LIMIT);

  // Next-state and next-fault decision. In the timed stages, a door-open
  // event is checked first, then the stage's own completion flag, then the
  // watchdog. This order makes a door fault beat completion, and makes
  // completion beat a timeout that lands on the same cycle.
  always_comb begin
    nxt_state  = cur_state;
    nxt_fault  = fault;
    stage_flag = 1'b0;
    adv_state  = cur_state;
    case (cur_state)
      S_IDLE: begin
        if (clear)
          nxt_fault = FAULT_NONE;
        else if (start && (fault == FAULT_NONE))
          nxt_state = S_DOOR_CHECK;
      end
      S_DOOR_CHECK: begin
        if (door_closed)
          nxt_state = S_FILL_WATER;
        else if (wd_hit) begin
          nxt_state = S_IDLE;
          nxt_fault = FAULT_NODOOR;
        end
      end
      S_FILL_WATER: begin
        stage_flag = sig_Full;
        adv_state  = cold_wash ? S_WASH : S_HEAT_WATER;
      end
      S_HEAT_WATER: begin
        stage_flag = sig_Temperature;
        adv_state  = S_WASH;
      end
      S_WASH: begin
        stage_flag = sig_Completed;
        adv_state  = S_RINSE;
      end
      S_RINSE: begin
        stage_flag = sig_Completed;
        adv_state  = S_SPIN;
      end
      S_SPIN: begin
        stage_flag = sig_Completed;
        adv_state  = S_DONE;
      end
      S_DONE: begin
        if (clear)
          nxt_state = S_IDLE;
      end
      default: nxt_state = S_IDLE;
    endcase

    if ((cur_state >= S_FILL_WATER) && (cur_state <= S_SPIN)) begin
      if (!door_closed) begin
        nxt_state = S_IDLE;
        nxt_fault = FAULT_DOOR;
      end else if (stage_flag) begin
        nxt_state = adv_state;
      end else if (wd_hit) begin
        nxt_state = S_IDLE;
        nxt_fault = FAULT_TIMEOUT;
      end
    end
  end

  // The output pattern is decoded from the state being entered. Because it is
  // registered on the same edge, the actuators always agree with `state`.
  // Bit order: water, heater, wash, spin, drain, lock, done.
  always_comb begin
    nxt_outs = 7'b0000000;
    case (nxt_state)
      S_DOOR_CHECK: nxt_outs = 7'b0000010;
      S_FILL_WATER: nxt_outs = 7'b1000010;
      S_HEAT_WATER: nxt_outs = 7'b0100010;
      S_WASH:       nxt_outs = 7'b0010010;
      S_RINSE:      nxt_outs = 7'b0010110;
      S_SPIN:       nxt_outs = 7'b0001110;
      S_DONE:       nxt_outs = 7'b0000001;
      default:      nxt_outs = 7'b0000000;
    endcase
  end

  // State, fault, watchdog and output registers. The watchdog restarts at
  // zero on every state change and saturates rather than wrapping.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cur_state   <= S_IDLE;
      fault       <= FAULT_NONE;
      watchdog    <= '0;
      water_valve <= 1'b0;
      heater      <= 1'b0;
      motor_wash  <= 1'b0;
      motor_spin  <= 1'b0;
      drain_valve <= 1'b0;
      door_lock   <= 1'b0;
      done        <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      fault     <= nxt_fault;
      if ((nxt_state != cur_state) || (cur_state == S_IDLE) || (cur_state == S_DONE))
        watchdog <= '0;
      else if (watchdog != '1)
        watchdog <= watchdog + 1'b1;
      {water_valve, heater, motor_wash, motor_spin, drain_valve, door_lock, done} <= nxt_outs;
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_wash_controller.sv
// tb_wash_controller
// ------------------
// Directed bench for wash_controller. A stage-level model, which counts the
// cycles spent in each stage, predicts state, fault and actuator outputs.
// These are compared every cycle. Literal checks at key points pin the model.

module tb_wash_controller;

  localparam int TO = 16;

  logic       clock;
  logic       reset_n;
  logic       start;
  logic       door_closed;
  logic       cold_wash;
  logic       clear;
  logic       sig_Full;
  logic       sig_Temperature;
  logic       sig_Completed;
  logic [2:0] state;
  logic       water_valve;
  logic       heater;
  logic       motor_wash;
  logic       motor_spin;
  logic       drain_valve;
  logic       door_lock;
  logic       done;
  logic [1:0] fault;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  wash_controller #(.STAGE_TIMEOUT(TO), .TO_WIDTH(8)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .door_closed(door_closed),
    .cold_wash(cold_wash), .clear(clear), .sig_Full(sig_Full),
    .sig_Temperature(sig_Temperature), .sig_Completed(sig_Completed),
    .state(state), .water_valve(water_valve), .heater(heater),
    .motor_wash(motor_wash), .motor_spin(motor_spin), .drain_valve(drain_valve),
    .door_lock(door_lock), .done(done), .fault(fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected outputs for each state.
  // Bit order: water, heater, wash, spin, drain, lock, done.
  localparam logic [6:0] OUT_TABLE [8] = '{
    7'b0000000, 7'b0000010, 7'b1000010, 7'b0100010,
    7'b0010010, 7'b0010110, 7'b0001110, 7'b0000001
  };

  typedef struct packed {
    int st;
    int flt;
    int cnt;
  } mdl_t;

  mdl_t mdl = '{st: 0, flt: 0, cnt: 0};

  // One edge of the stage-level model. cnt is the number of cycles already
  // completed in the current stage. A stage times out on its TO-th cycle.
  function automatic mdl_t model_step(input mdl_t m);
    mdl_t r;
    logic flag;
    int   nxt;
    r = m;
    if (!reset_n) begin
      r.st = 0; r.flt = 0; r.cnt = 0;
      return r;
    end
    case (m.st)
      0: begin
        if (clear) r.flt = 0;
        else if (start && m.flt == 0) r.st = 1;
      end
      1: begin
        if (door_closed) r.st = 2;
        else if (m.cnt + 1 >= TO) begin r.st = 0; r.flt = 3; end
      end
      7: if (clear) r.st = 0;
      default: begin
        flag = (m.st == 2) ? sig_Full : (m.st == 3) ? sig_Temperature : sig_Completed;
        nxt  = (m.st == 2 && cold_wash) ? 4 : m.st + 1;
        if (!door_closed) begin r.st = 0; r.flt = 1; end
        else if (flag) r.st = nxt;
        else if (m.cnt + 1 >= TO) begin r.st = 0; r.flt = 2; end
      end
    endcase
    if (r.st != m.st) r.cnt = 0;
    else if (m.st >= 1 && m.st <= 6) r.cnt = m.cnt + 1;
    else r.cnt = 0;
    return r;
  endfunction

  always @(posedge clock) mdl <= model_step(mdl);

  // Every-cycle comparison of the DUT against the model, on the falling edge.
  always @(negedge clock) begin
    if (chk_en) begin
      total++;
      if ({state, fault, water_valve, heater, motor_wash, motor_spin, drain_valve, door_lock, done}
          != {3'(mdl.st), 2'(mdl.flt), OUT_TABLE[mdl.st]}) begin
        bad++;
        $display("[TB] FAIL model_cmp t=%0t: got state=%0d fault=%0d outs=%b, want state=%0d fault=%0d outs=%b",
                 $time, state, fault,
                 {water_valve, heater, motor_wash, motor_spin, drain_valve, door_lock, done},
                 mdl.st, mdl.flt, OUT_TABLE[mdl.st]);
      end
    end
  end

  // Drive one input vector for n consecutive edges. The task returns shortly
  // after the last edge.
  task automatic applyStimulus(input int n, input logic rn, input logic st, input logic door,
                               input logic cold, input logic clr, input logic full,
                               input logic temp, input logic comp);
    reset_n = rn; start = st; door_closed = door; cold_wash = cold; clear = clr;
    sig_Full = full; sig_Temperature = temp; sig_Completed = comp;
    repeat (n) @(posedge clock);
    #2;
  endtask

  // Hand-computed literal expectation.
  task automatic checkOutput(input string name, input logic [2:0] exp_st,
                             input logic [1:0] exp_flt, input logic [6:0] exp_outs);
    logic [6:0] outs;
    outs = {water_valve, heater, motor_wash, motor_spin, drain_valve, door_lock, done};
    total++;
    if ({state, fault, outs} != {exp_st, exp_flt, exp_outs}) begin
      bad++;
      $display("[TB] FAIL %s: got state=%0d fault=%0d outs=%b, want state=%0d fault=%0d outs=%b",
               name, state, fault, outs, exp_st, exp_flt, exp_outs);
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; door_closed = 1'b0; cold_wash = 1'b0; clear = 1'b0;
    sig_Full = 1'b0; sig_Temperature = 1'b0; sig_Completed = 1'b0;
    #2;
    // Argument order: n, reset_n, start, door, cold, clear, full, temp, comp.
    applyStimulus(2, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    checkOutput("reset", 3'd0, 2'b00, 7'b0000000);

    // Normal hot cycle; each flag arrives on the third cycle of its stage.
    applyStimulus(1, 1, 1, 1, 0, 0, 0, 0, 0);
    checkOutput("door_check", 3'd1, 2'b00, 7'b0000010);
    applyStimulus(1, 1, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("fill", 3'd2, 2'b00, 7'b1000010);
    applyStimulus(2, 1, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 1, 0, 0, 1, 0, 0);
    checkOutput("heat", 3'd3, 2'b00, 7'b0100010);
    applyStimulus(2, 1, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 1, 0, 0, 0, 1, 0);
    checkOutput("wash", 3'd4, 2'b00, 7'b0010010);
    applyStimulus(2, 1, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 1, 0, 0, 0, 0, 1);
    checkOutput("rinse", 3'd5, 2'b00, 7'b0010110);
    applyStimulus(2, 1, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 1, 0, 0, 0, 0, 1);
    checkOutput("spin", 3'd6, 2'b00, 7'b0001110);
    applyStimulus(2, 1, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 1, 0, 0, 0, 0, 1);
    checkOutput("done", 3'd7, 2'b00, 7'b0000001);
    applyStimulus(3, 1, 0, 1, 0, 0, 0, 0, 1);
    checkOutput("done_hold", 3'd7, 2'b00, 7'b0000001);
    applyStimulus(1, 1, 0, 1, 0, 1, 0, 0, 0);
    checkOutput("done_clear", 3'd0, 2'b00, 7'b0000000);

    // Cold wash skips heating.
    applyStimulus(1, 1, 1, 1, 1, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 1, 1, 0, 0, 0, 0);
    applyStimulus(2, 1, 0, 1, 1, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 1, 1, 0, 1, 0, 0);
    checkOutput("cold_skip", 3'd4, 2'b00, 7'b0010010);

    // Door opened during WASH, then start is locked out until clear.
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("door_open", 3'd0, 2'b01, 7'b0000000);
    applyStimulus(2, 1, 1, 1, 0, 0, 0, 0, 0);
    checkOutput("start_blocked", 3'd0, 2'b01, 7'b0000000);
    applyStimulus(1, 1, 1, 1, 0, 1, 0, 0, 0);
    checkOutput("clear_with_start", 3'd0, 2'b00, 7'b0000000);

    // Timeout in HEAT_WATER.
    applyStimulus(1, 1, 1, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 1, 0, 0, 1, 0, 0);
    applyStimulus(TO - 1, 1, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("heat_before_to", 3'd3, 2'b00, 7'b0100010);
    applyStimulus(1, 1, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("heat_timeout", 3'd0, 2'b10, 7'b0000000);
    applyStimulus(1, 1, 0, 1, 0, 1, 0, 0, 0);

    // Completion on the last allowed cycle wins over the timeout.
    applyStimulus(1, 1, 1, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 1, 0, 0, 1, 0, 0);
    applyStimulus(TO - 1, 1, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 1, 0, 0, 0, 1, 0);
    checkOutput("complete_beats_to", 3'd4, 2'b00, 7'b0010010);

    // Door fault beats completion in the same cycle.
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("door_beats_done", 3'd0, 2'b01, 7'b0000000);
    applyStimulus(1, 1, 0, 1, 0, 1, 0, 0, 0);

    // Reset in the middle of SPIN.
    applyStimulus(1, 1, 1, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 1, 0, 0, 1, 0, 0);
    applyStimulus(1, 1, 0, 1, 0, 0, 0, 1, 0);
    applyStimulus(1, 1, 0, 1, 0, 0, 0, 0, 1);
    applyStimulus(1, 1, 0, 1, 0, 0, 0, 0, 1);
    checkOutput("spin_again", 3'd6, 2'b00, 7'b0001110);
    applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("reset_mid", 3'd0, 2'b00, 7'b0000000);

    // The door never closes, so the cycle ends after 16 cycles in DOOR_CHECK.
    applyStimulus(1, 1, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(TO - 1, 1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("door_wait", 3'd1, 2'b00, 7'b0000010);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("door_never", 3'd0, 2'b11, 7'b0000000);
    applyStimulus(2, 1, 0, 1, 0, 1, 0, 0, 0);
    checkOutput("final_clear", 3'd0, 2'b00, 7'b0000000);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
